// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller for the 5-stage RISC-V core: turns stall, branch and memory-busy
// requests into register write enables/flushes, and counts stall and flush cycles.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop_req,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             pc_sel_br,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StLstall = 2'd1,
        StMwait  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Kept as a plain vector so the unused encoding 3 stays representable.
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic             flush_ev;

    always_comb begin
        pc_we       = 1'b1;
        pc_sel_br   = 1'b0;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_flush  = 1'b0;
        exmem_we    = 1'b1;
        memwb_flush = 1'b0;
        flush_ev    = 1'b0;
        state_d     = StRun;
        if (!rst) begin
            if (mem_busy) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_we    = 1'b0;
                memwb_flush = 1'b1;
                state_d     = StMwait;
            end else if (branch_taken) begin
                pc_sel_br  = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_ev   = 1'b1;
                state_d    = StRun;
            end else if (stop_req && (state_q == StRun || state_q == StMwait)) begin
                // LSTALL and the illegal encoding mask stop_req.
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                state_d    = StLstall;
            end else begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            if (cnt_clr) begin
                stall_q <= '0;
                flush_q <= '0;
            end else begin
                if (!pc_we && stall_q != CntMax) begin
                    stall_q <= stall_q + CntOne;
                end
                if (flush_ev && flush_q != CntMax) begin
                    flush_q <= flush_q + CntOne;
                end
            end
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios followed by random stimulus, all checked
// against an event-level reference model with 4-bit counters.
module tb_pipe_ctrl;

    localparam int W    = 4;
    localparam int CMAX = 15;

    logic         clk = 1'b0;
    logic         rst, stop_req, branch_taken, mem_busy, cnt_clr;
    logic         pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we;
    logic         memwb_flush;
    logic [1:0]   state;
    logic [W-1:0] stall_cnt, flush_cnt;

    int total_n = 0;
    int pass_n  = 0;
    int fail_n  = 0;
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipe_ctrl #(.CNT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stop_req    (stop_req),
        .branch_taken(branch_taken),
        .mem_busy    (mem_busy),
        .cnt_clr     (cnt_clr),
        .pc_we       (pc_we),
        .pc_sel_br   (pc_sel_br),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_we     (idex_we),
        .idex_flush  (idex_flush),
        .exmem_we    (exmem_we),
        .memwb_flush (memwb_flush),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    // Events: 0 none, 1 freeze, 2 branch flush, 3 load-use stall.
    function automatic int event_of(input logic r, sr, bt, mb, input int s);
        if (r) return 0;
        if (mb) return 1;
        if (bt) return 2;
        if (sr && (s == 0 || s == 2)) return 3;
        return 0;
    endfunction

    // Bit order: pc_we pc_sel_br ifid_we ifid_flush idex_we idex_flush exmem_we memwb_flush
    function automatic int outs_of(input int ev);
        case (ev)
            1:       return 'b0000_0001;
            2:       return 'b1111_1110;
            3:       return 'b0000_1110;
            default: return 'b1010_1010;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input logic r, sr, bt, mb);
        int obs;
        obs = {24'd0, pc_we, pc_sel_br, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
               memwb_flush};
        check("outputs", obs, outs_of(event_of(r, sr, bt, mb, m_state)));
        check("state", int'(state), m_state);
        check("stall_cnt", int'(stall_cnt), m_stall);
        check("flush_cnt", int'(flush_cnt), m_flush);
    endtask

    task automatic model_edge(input logic r, sr, bt, mb, clr);
        int ev;
        ev = event_of(r, sr, bt, mb, m_state);
        if (r) begin
            m_state = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_state = (ev == 1) ? 2 : (ev == 3) ? 1 : 0;
            if (clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if ((ev == 1 || ev == 3) && m_stall < CMAX) m_stall++;
                if (ev == 2 && m_flush < CMAX) m_flush++;
            end
        end
    endtask

    task automatic step(input logic r, sr, bt, mb, clr);
        rst          = r;
        stop_req     = sr;
        branch_taken = bt;
        mem_busy     = mb;
        cnt_clr      = clr;
        #1;
        check_now(r, sr, bt, mb);
        @(posedge clk);
        model_edge(r, sr, bt, mb, clr);
        #1;
    endtask

    initial begin
        rst = 1'b1; stop_req = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);

        // Single load-use stall, then masked while stop_req is held.
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("stall_after_lu", int'(stall_cnt), 1);

        // Branch wins over a simultaneous stall request.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("flush_after_br", int'(flush_cnt), 1);

        // Memory freeze holds a pending branch for three cycles.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        check("stall_after_frz", int'(stall_cnt), 3);

        // Saturation, then clear alongside a stall.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
        check("stall_sat", int'(stall_cnt), CMAX);
        step(0, 0, 0, 1, 1);
        check("stall_clr", int'(stall_cnt), 0);

        // Reset while frozen in MWAIT.
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("rst_state", int'(state), 0);

        // Illegal encoding recovers to RUN with default outputs.
        step(0, 1, 0, 0, 0);
        stop_req = 1'b1;
        force dut.state_q = 2'd3;
        m_state = 3;
        #1;
        check_now(0, 1, 0, 0);
        release dut.state_q;
        @(posedge clk);
        model_edge(0, 1, 0, 0, 0);
        #1;
        check("illegal_recover", int'(state), 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 40),
                 ($urandom_range(99) < 20), ($urandom_range(99) < 20),
                 ($urandom_range(99) < 3));
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Consumer side of the load-use hazard signal: takes the ID-stage stall request, the EX-stage branch-taken signal and the data-memory busy signal.
- Drives the pipeline-register write enables and flushes, plus the PC write enable and select, for the 5-stage RISC-V core.
- Holds the state a single combinational detector cannot: masking a repeated load-use stall, tracking multi-cycle memory freezes, and counting stall and flush cycles for performance monitoring.

Parameters:
CNT_W, 16, width of the saturating stall and flush counters.

Ports:
clk  in  1  pipeline clock; all state updates on its rising edge.
rst  in  1  reset, synchronous, active-high.
stop_req  in  1  load-use hazard request from the ID/EX hazard detector.
branch_taken  in  1  EX stage resolved a taken branch or jump this cycle.
mem_busy  in  1  data memory cannot complete this cycle.
cnt_clr  in  1  synchronous clear of both counters.
pc_we  out  1  PC register write enable.
pc_sel_br  out  1  PC loads the branch target (1) or PC+4 (0).
ifid_we  out  1  IF/ID register write enable.
ifid_flush  out  1  IF/ID loads a NOP (addi x0,x0,0 = 32'h00000013).
idex_we  out  1  ID/EX register write enable.
idex_flush  out  1  ID/EX loads a bubble.
exmem_we  out  1  EX/MEM register write enable.
memwb_flush  out  1  MEM/WB loads a bubble.
state  out  2  current FSM state: RUN=0, LSTALL=1, MWAIT=2.
stall_cnt  out  CNT_W  cycles with pc_we=0.
flush_cnt  out  CNT_W  number of branch flushes.

Behaviour:
- FSM is registered; all control outputs are combinational from (state, inputs).
- Priority: mem_busy > branch_taken > stop_req.
- Reset: state=RUN, stall_cnt=0, flush_cnt=0. While rst=1, outputs take the RUN/no-event values:
  - all *_we=1;
  - all flushes=0;
  - pc_sel_br=0.
- Default (no event): pc_we=ifid_we=idex_we=exmem_we=1; pc_sel_br=ifid_flush=idex_flush=memwb_flush=0.
- mem_busy=1, any state (FREEZE):
  - pc_we=ifid_we=idex_we=exmem_we=0; memwb_flush=1; all other outputs 0.
  - branch_taken and stop_req are ignored; they are re-presented by the frozen stages afterwards.
  - Next state MWAIT.
- MWAIT with mem_busy=0: default outputs, with branch_taken/stop_req evaluated exactly as in RUN. Next state follows the RUN rules.
- branch_taken=1, mem_busy=0, any state:
  - pc_we=1, pc_sel_br=1, ifid_flush=1, idex_flush=1; other enables 1.
  - Next state RUN.
  - flush_cnt += 1.
  - A simultaneous stop_req is dropped; the stalled instruction is being squashed.
- RUN, stop_req=1, no higher-priority event:
  - pc_we=0, ifid_we=0, idex_flush=1, idex_we=1, exmem_we=1.
  - Next state LSTALL.
- LSTALL:
  - stop_req is masked, giving at most one load-use stall per instruction; default outputs unless mem_busy or branch_taken.
  - Next state RUN, or MWAIT if mem_busy.
- Counters:
  - stall_cnt += 1 on every cycle with pc_we=0.
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clr=1 sets both to 0 on the next edge; it has priority over increment that cycle.
- Illegal state 3 → RUN on the next edge, with default outputs while in it.

Test Plan:
1. After rst, drive a 1-cycle stop_req → that cycle pc_we=0, ifid_we=0, idex_flush=1. Next cycle: state=1 and outputs are default even with stop_req held 1. Then state=0. stall_cnt=1.
2. branch_taken and stop_req both 1 in RUN → pc_sel_br=1, ifid_flush=idex_flush=1, pc_we=1; state stays 0; flush_cnt=1, stall_cnt=0.
3. mem_busy held 3 cycles with branch_taken=1 throughout → 3 freeze cycles with all enables 0 and memwb_flush=1. On the 4th cycle (mem_busy=0) the branch flush occurs. stall_cnt=3, flush_cnt=1.
4. CNT_W=4, 20 consecutive stall cycles → stall_cnt stops at 15. Then assert cnt_clr alongside a stall → stall_cnt=0 on the next edge.
5. Assert rst during MWAIT with mem_busy=1 → next edge: state=0, counters 0. While rst is high, outputs are default.
6. Force state=3 via mem_busy pattern or backdoor → returns to state=0 within one cycle with default outputs.
